// File: rtl/operand_fetch_pkg.sv
// ============================================================================
//  Module      : operand_fetch_pkg
//  Description : Shared source-mode codes, FSM state codes and small decode
//                helpers for the operand fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package operand_fetch_pkg;

    // Source-select field encodings
    localparam logic [2:0] SRC_RR     = 3'b000;
    localparam logic [2:0] SRC_RU4    = 3'b001;
    localparam logic [2:0] SRC_U8L    = 3'b010;
    localparam logic [2:0] SRC_U8H    = 3'b011;
    localparam logic [2:0] SRC_PREFIX = 3'b100;
    localparam logic [2:0] SRC_EXT    = 3'b101;

    // FSM state codes
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    // Modes whose A operand comes from the fixed accumulator register
    function automatic logic uses_acc(input logic [2:0] src);
        return (src == SRC_U8L) || (src == SRC_U8H) || (src == SRC_EXT);
    endfunction

    // Modes that produce an operand pair for the ALU
    function automatic logic is_issue(input logic [2:0] src);
        return (src[2] == 1'b0) || (src == SRC_EXT);
    endfunction

    // 110 / 111 are reserved encodings
    function automatic logic is_reserved(input logic [2:0] src);
        return src[2] && src[1];
    endfunction

endpackage

`default_nettype wire

// File: rtl/operand_fetch_if.sv
// ============================================================================
//  Module      : operand_fetch_if
//  Description : Decode / register-file / execute bundle around the operand
//                fetch stage. The master is the surrounding pipeline, the
//                slave is the fetch block.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface operand_fetch_if #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        sourcex;
    logic [3:0]        arg_a;
    logic [3:0]        arg_b;
    logic [REG_AW-1:0] addr_a;
    logic [REG_AW-1:0] addr_b;
    logic [DATA_W-1:0] reg_a;
    logic [DATA_W-1:0] reg_b;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [REG_AW-1:0] out_rd;
    logic              err_prefix;
    logic              err_mode;

    modport master (
        output flush, in_valid, sourcex, arg_a, arg_b, reg_a, reg_b, out_ready,
        input  in_ready, addr_a, addr_b, out_valid, alu_a, alu_b, out_rd,
               err_prefix, err_mode
    );

    modport slave (
        input  flush, in_valid, sourcex, arg_a, arg_b, reg_a, reg_b, out_ready,
        output in_ready, addr_a, addr_b, out_valid, alu_a, alu_b, out_rd,
               err_prefix, err_mode
    );
endinterface

`default_nettype wire

// File: rtl/operand_fetch_imm_prefix_acc.sv
// ============================================================================
//  Module      : imm_prefix_acc
//  Description : Prefix immediate accumulator. Shifts instruction bytes into
//                the EXT register, counts consecutive prefixes with
//                saturation and flags prefix overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_prefix_acc #(
    parameter int DATA_W     = 16,
    parameter int PREFIX_MAX = 2
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              flush,
    input  wire logic              shift_en,
    input  wire logic              clear,
    input  wire logic [7:0]        byte_in,
    output logic      [DATA_W-9:0] ext,
    output logic                   err_prefix
);
    localparam int EXT_W = DATA_W - 8;
    localparam int CNT_W = (PREFIX_MAX < 1) ? 1 : $clog2(PREFIX_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PREFIX_MAX);

    logic [EXT_W-1:0] ext_q;
    logic [EXT_W-1:0] ext_shift;
    logic [CNT_W-1:0] cnt;
    logic             at_max;
    logic             err_q;

    // The oldest byte falls off the top once EXT is full
    generate
        if (EXT_W > 8) begin : g_shift_wide
            assign ext_shift = {ext_q[EXT_W-9:0], byte_in};
        end else begin : g_shift_byte
            assign ext_shift = byte_in;
        end
    endgenerate

    assign at_max = (cnt == CNT_MAX);

    // EXT register and saturating prefix counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_q <= '0;
            cnt   <= '0;
        end else if (flush || clear) begin
            ext_q <= '0;
            cnt   <= '0;
        end else if (shift_en) begin
            ext_q <= ext_shift;
            if (!at_max) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // One-cycle overflow pulse when a prefix arrives with the counter saturated
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= shift_en && !flush && at_max;
        end
    end

    assign ext        = ext_q;
    assign err_prefix = err_q;

endmodule

`default_nettype wire

// File: rtl/operand_fetch.sv
// ============================================================================
//  Module      : operand_fetch
//  Description : Registered ALU operand fetch stage. Decodes the source mode,
//                drives RF read addresses, captures RF data one cycle later,
//                merges immediates and presents operands on valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int REG_AW     = 4,
    parameter int ACC_REG    = 8,
    parameter int PREFIX_MAX = 2
) (
    input wire logic         clk,
    input wire logic         rst_n,
    operand_fetch_if.slave   bus
);
    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              in_ready;
    logic              out_valid;
    logic              accept;
    logic              acc_issue;
    logic              acc_prefix;
    logic              acc_clear;
    logic [7:0]        imm_byte;
    logic [DATA_W-9:0] ext;
    logic [DATA_W-1:0] imm_val;
    logic [REG_AW-1:0] addr_a_sel;
    logic [REG_AW-1:0] addr_b_sel;
    logic              pend_rr;
    logic [DATA_W-1:0] pend_imm;
    logic [REG_AW-1:0] pend_rd;
    logic [DATA_W-1:0] alu_a_q;
    logic [DATA_W-1:0] alu_b_q;
    logic [REG_AW-1:0] out_rd_q;
    logic              err_mode_q;

    assign imm_byte   = {bus.arg_a, bus.arg_b};
    assign accept     = bus.in_valid && in_ready;
    assign acc_issue  = accept && is_issue(bus.sourcex);
    assign acc_prefix = accept && (bus.sourcex == SRC_PREFIX);
    assign acc_clear  = accept && (bus.sourcex != SRC_PREFIX);

    // RF read addresses follow the instruction fields with no register stage
    always_comb begin
        addr_a_sel = uses_acc(bus.sourcex) ? REG_AW'(ACC_REG) : REG_AW'(bus.arg_a);
        addr_b_sel = (bus.sourcex == SRC_RR) ? REG_AW'(bus.arg_b) : '0;
    end

    // Immediate for the B operand, fixed at accept time
    always_comb begin
        imm_val = '0;
        case (bus.sourcex)
            SRC_RU4: imm_val = DATA_W'(bus.arg_b);
            SRC_U8L: imm_val = DATA_W'(imm_byte);
            SRC_U8H: imm_val = {imm_byte, {(DATA_W-8){1'b0}}};
            SRC_EXT: imm_val = {ext, imm_byte};
            default: imm_val = '0;
        endcase
    end

    imm_prefix_acc #(
        .DATA_W     (DATA_W),
        .PREFIX_MAX (PREFIX_MAX)
    ) u_imm_prefix_acc (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (bus.flush),
        .shift_en   (acc_prefix),
        .clear      (acc_clear),
        .byte_in    (imm_byte),
        .ext        (ext),
        .err_prefix (bus.err_prefix)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state: flush overrides everything
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (acc_issue) state_nxt = ST_FETCH;
            ST_FETCH: state_nxt = ST_HOLD;
            ST_HOLD:  if (bus.out_ready) state_nxt = acc_issue ? ST_FETCH : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
        if (bus.flush) begin
            state_nxt = ST_IDLE;
        end
    end

    // FSM outputs: handshake flags
    always_comb begin
        in_ready  = !bus.flush && ((state == ST_IDLE) ||
                                   ((state == ST_HOLD) && bus.out_ready));
        out_valid = (state == ST_HOLD);
    end

    // Per-op context held from accept until RF data returns
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_rr  <= 1'b0;
            pend_imm <= '0;
            pend_rd  <= '0;
        end else if (acc_issue) begin
            pend_rr  <= (bus.sourcex == SRC_RR);
            pend_imm <= imm_val;
            pend_rd  <= addr_a_sel;
        end
    end

    // Operand register: loaded only in FETCH so it is frozen throughout HOLD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            out_rd_q <= '0;
        end else if ((state == ST_FETCH) && !bus.flush) begin
            alu_a_q  <= bus.reg_a;
            alu_b_q  <= pend_rr ? bus.reg_b : pend_imm;
            out_rd_q <= pend_rd;
        end
    end

    // Reserved-mode pulse, one cycle after the dropped accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_mode_q <= 1'b0;
        end else begin
            err_mode_q <= accept && is_reserved(bus.sourcex);
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.addr_a    = addr_a_sel;
    assign bus.addr_b    = addr_b_sel;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.out_rd    = out_rd_q;
    assign bus.err_mode  = err_mode_q;

endmodule

`default_nettype wire

// File: tb/tb_operand_fetch.sv
// ============================================================================
//  Module      : tb_operand_fetch
//  Description : Scoreboard bench for operand_fetch (DATA_W=32).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_operand_fetch;
    import operand_fetch_pkg::*;

    localparam int DATA_W     = 32;
    localparam int REG_AW     = 4;
    localparam int ACC_REG    = 8;
    localparam int PREFIX_MAX = 2;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [REG_AW-1:0] rd;
    } op_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    operand_fetch_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) bus ();

    operand_fetch #(
        .DATA_W     (DATA_W),
        .REG_AW     (REG_AW),
        .ACC_REG    (ACC_REG),
        .PREFIX_MAX (PREFIX_MAX)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Register file model: synchronous read, one cycle latency
    logic [DATA_W-1:0] rf [16];
    always @(posedge clk) begin
        bus.reg_a <= rf[bus.addr_a];
        bus.reg_b <= rf[bus.addr_b];
    end

    int total = 0;
    int bad   = 0;
    op_t exp_q[$];
    logic [DATA_W-9:0] m_ext = '0;
    int   m_cnt = 0;
    logic exp_errp = 1'b0;
    logic exp_errm = 1'b0;
    logic last_rdy = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, req, $time);
        end
    endtask

    // Reference model of one accepted instruction
    task automatic model_accept(input logic [2:0] src, input logic [3:0] a, input logic [3:0] b);
        logic [7:0] bb;
        op_t op;
        bb = {a, b};
        if (src == 3'b100) begin
            exp_errp = (m_cnt == PREFIX_MAX);
            if (m_cnt < PREFIX_MAX) m_cnt++;
            m_ext = (m_ext << 8) | (DATA_W-8)'(bb);
        end else if (src >= 3'b110) begin
            exp_errm = 1'b1;
            m_ext = '0;
            m_cnt = 0;
        end else begin
            op.rd = (src == 3'b010 || src == 3'b011 || src == 3'b101) ? 4'(ACC_REG) : a;
            op.a  = rf[op.rd];
            case (src)
                3'b000:  op.b = rf[b];
                3'b001:  op.b = DATA_W'(b);
                3'b010:  op.b = DATA_W'(bb);
                3'b011:  op.b = DATA_W'(bb) << (DATA_W - 8);
                default: op.b = {m_ext, bb};
            endcase
            exp_q.push_back(op);
            m_ext = '0;
            m_cnt = 0;
        end
    endtask

    // One cycle of stimulus, entered and left on a falling edge
    task automatic step(input logic v, input logic [2:0] src, input logic [3:0] a,
                        input logic [3:0] b, input logic ordy, input logic fl);
        logic [3:0] eaa;
        logic [3:0] eab;
        check("err_prefix", bus.err_prefix, exp_errp);
        check("err_mode", bus.err_mode, exp_errm);
        exp_errp = 1'b0;
        exp_errm = 1'b0;
        bus.in_valid  = v;
        bus.sourcex   = src;
        bus.arg_a     = a;
        bus.arg_b     = b;
        bus.out_ready = ordy;
        bus.flush     = fl;
        #1;
        eaa = (src == 3'b010 || src == 3'b011 || src == 3'b101) ? 4'(ACC_REG) : a;
        eab = (src == 3'b000) ? b : 4'd0;
        check("addr_a", bus.addr_a, eaa);
        check("addr_b", bus.addr_b, eab);
        last_rdy = bus.in_ready;
        if (v && bus.in_ready) model_accept(src, a, b);
        if (fl) begin
            m_ext = '0;
            m_cnt = 0;
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) step(1'b0, 3'b000, 4'd0, 4'd0, ordy, 1'b0);
    endtask

    // Monitor: pops and compares on every handshake, checks hold stability
    op_t  snap;
    logic held = 1'b0;
    initial begin
        op_t got;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    check("hold_valid", bus.out_valid, 1'b1);
                    check("hold_alu_a", bus.alu_a, snap.a);
                    check("hold_alu_b", bus.alu_b, snap.b);
                    check("hold_rd", bus.out_rd, snap.rd);
                end
                held    = bus.out_valid && !bus.out_ready && !bus.flush;
                snap.a  = bus.alu_a;
                snap.b  = bus.alu_b;
                snap.rd = bus.out_rd;
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_issue", 64'd1, 64'd0);
                    end else begin
                        got = exp_q.pop_front();
                        check("alu_a", bus.alu_a, got.a);
                        check("alu_b", bus.alu_b, got.b);
                        check("out_rd", bus.out_rd, got.rd);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] src;
        logic       ordy;
        logic       fl;
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.sourcex = '0;
        bus.arg_a = '0;   bus.arg_b = '0;      bus.out_ready = 1'b0;
        for (int i = 0; i < 16; i++) rf[i] = $urandom;
        rf[3] = 32'h0000_1234;
        rf[5] = 32'h0000_00FF;
        rf[8] = 32'h0000_0001;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_valid", bus.out_valid, 1'b0);
        check("rst_alu_a", bus.alu_a, '0);
        check("rst_alu_b", bus.alu_b, '0);
        check("rst_rd", bus.out_rd, '0);
        rst_n = 1'b1;
        @(negedge clk);

        // RR with latency check: FETCH after accept edge, HOLD one edge later
        step(1'b1, SRC_RR, 4'd3, 4'd5, 1'b0, 1'b0);
        check("lat_fetch", bus.out_valid, 1'b0);
        step(1'b0, SRC_RR, 4'd0, 4'd0, 1'b0, 1'b0);
        check("lat_hold", bus.out_valid, 1'b1);
        idle(2, 1'b1);

        // U8H / U8L
        step(1'b1, SRC_U8H, 4'hA, 4'hB, 1'b1, 1'b0);
        idle(3, 1'b1);
        step(1'b1, SRC_U8L, 4'hA, 4'hB, 1'b1, 1'b0);
        idle(3, 1'b1);

        // Prefix chain into EXT, then EXT with cleared prefix
        step(1'b1, SRC_PREFIX, 4'h1, 4'h2, 1'b1, 1'b0);
        step(1'b1, SRC_PREFIX, 4'h3, 4'h4, 1'b1, 1'b0);
        step(1'b1, SRC_EXT,    4'h5, 4'h6, 1'b1, 1'b0);
        idle(3, 1'b1);
        step(1'b1, SRC_EXT,    4'h5, 4'h6, 1'b1, 1'b0);
        idle(3, 1'b1);

        // Prefix overflow: third and fourth prefixes pulse, top byte lost
        step(1'b1, SRC_PREFIX, 4'h1, 4'h1, 1'b1, 1'b0);
        step(1'b1, SRC_PREFIX, 4'h2, 4'h2, 1'b1, 1'b0);
        step(1'b1, SRC_PREFIX, 4'h3, 4'h3, 1'b1, 1'b0);
        step(1'b1, SRC_PREFIX, 4'h4, 4'h4, 1'b1, 1'b0);
        step(1'b1, SRC_EXT,    4'h5, 4'h5, 1'b1, 1'b0);
        idle(3, 1'b1);

        // Reserved modes
        step(1'b1, 3'b110, 4'h1, 4'h2, 1'b1, 1'b0);
        step(1'b1, 3'b111, 4'h3, 4'h4, 1'b1, 1'b0);
        idle(1, 1'b1);

        // Backpressure in HOLD, then back-to-back issue on release
        step(1'b1, SRC_RR, 4'd1, 4'd2, 1'b0, 1'b0);
        idle(1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, SRC_RU4, 4'd9, 4'd7, 1'b0, 1'b0);
            check("bp_in_ready", last_rdy, 1'b0);
        end
        step(1'b1, SRC_RR, 4'd4, 4'd6, 1'b1, 1'b0);
        check("b2b_in_ready", last_rdy, 1'b1);
        idle(1, 1'b0);
        check("b2b_valid", bus.out_valid, 1'b1);
        idle(2, 1'b1);

        // Flush during FETCH drops the op
        step(1'b1, SRC_RR, 4'd7, 4'd9, 1'b0, 1'b0);
        step(1'b0, SRC_RR, 4'd0, 4'd0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            idle(1, 1'b1);
            check("flush_valid", bus.out_valid, 1'b0);
        end

        // Asynchronous reset mid-HOLD
        step(1'b1, SRC_RR, 4'd3, 4'd5, 1'b0, 1'b0);
        idle(1, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        check("arst_valid", bus.out_valid, 1'b0);
        check("arst_alu_a", bus.alu_a, '0);
        check("arst_alu_b", bus.alu_b, '0);
        check("arst_rd", bus.out_rd, '0);
        exp_q.delete();
        m_ext = '0;
        m_cnt = 0;
        exp_errp = 1'b0;
        exp_errm = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Randomized traffic; flush only while the consumer is stalled
        for (int n = 0; n < 600; n++) begin
            src  = 3'($urandom_range(0, 7));
            ordy = ($urandom_range(0, 3) != 0);
            fl   = ($urandom_range(0, 24) == 0);
            if (fl) ordy = 1'b0;
            step($urandom_range(0, 3) != 0, src, 4'($urandom), 4'($urandom), ordy, fl);
        end

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1, 1'b1);
        check("drain_empty", exp_q.size(), 0);
        idle(1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
